ecc_ram_port_arbiter: RTL and testbench

- Single-clock controller that shares one port of the ECC-protected true-dual-port RAM (tdpram_with_ecc, port A side) between two requesters.
- Round-robin arbitration with valid/ready handshakes on the requester side.
- Tagged read responses carry the RAM's decoded data and error flag.
- Counts ECC events; optionally runs a background scrubber that writes corrected data back.

---
 rtl/ecc_ram_pkg.sv | 31 +++
 rtl/rr_arb2.sv | 40 ++++
 rtl/ecc_ram_port_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_ecc_ram_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_ram_pkg.sv
// rtl/ecc_ram_pkg.sv - shared types and helpers for the ECC RAM port arbiter
//
// Contents:
//   req_op_t       selected request (we, addr, wdata), sized to the widest supported port
//   scrub_state_t  background scrubber states
//   depthOf()      word count of a RAM with the given address width
package ecc_ram_pkg;

  // Ceiling widths for req_op_t; instances narrow these with width casts.
  localparam int unsigned REQ_ADDR_MAX_W = 16;
  localparam int unsigned REQ_DATA_MAX_W = 64;

  typedef struct packed {
    logic                      we;
    logic [REQ_ADDR_MAX_W-1:0] addr;
    logic [REQ_DATA_MAX_W-1:0] wdata;
  } req_op_t;

  typedef enum logic [2:0] {
    IDLE,
    SCRUB_RD,
    SCRUB_WAIT,
    SCRUB_CHK,
    SCRUB_WB
  } scrub_state_t;

  function automatic int unsigned depthOf(input int unsigned addrWidth);
    return 32'd1 << addrWidth;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, pointer moves only on a handshake
//
// Ports:
//   clk     clock
//   rstn    synchronous active-low reset (requester 0 wins the first tie)
//   enable  0 forces grant to zero
//   valid   per-requester request valid
//   grant   one-hot or zero; a grant is a handshake since it implies valid
module rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  // Index of the requester granted on the most recent handshake.
  logic lastGrant;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = lastGrant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lastGrant <= 1'b1;
    end else if (|grant) begin
      lastGrant <= grant[1];
    end
  end

endmodule

// File: rtl/ecc_ram_port_arbiter.sv
// rtl/ecc_ram_port_arbiter.sv - shares one ECC RAM port between two requesters
//
// Ports:
//   clk, rstn                          clock, synchronous active-low reset
//   req_valid/ready/we/addr/wdata      two packed requesters, handshake on valid&ready
//   rsp_valid/id/rdata/err             one pulse per completed read, in issue order
//   ram_en/we/addr/din                 registered RAM port drive
//   ram_dout/ram_err                   RAM decoded data and error flag, one cycle after a read
//   err_cnt                            saturating count of reads that returned ram_err
//   scrub_busy                         background scrubber owns the RAM port
// Build option: ECC_SCRUB_EN adds the idle-time scrubber; otherwise scrub_busy is 0.
module ecc_ram_port_arbiter
  import ecc_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 3,
  parameter int ERR_CNT_W      = 8,
  parameter int SCRUB_INTERVAL = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic                    rsp_id,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  input  logic [DATA_WIDTH-1:0]   ram_dout,
  input  logic                    ram_err,
  output logic [ERR_CNT_W-1:0]    err_cnt,
  output logic                    scrub_busy
);

  logic       scrubBusy;
  logic       scrubIssueRd;
  logic       scrubIssueWb;
  logic [1:0] grant;
  logic       accept;
  logic       grantIdx;
  req_op_t    selOp;
  logic       issueId;
  logic       issueScrub;
  logic       rdPend;
  logic       rdId;
  logic       rdScrub;
  logic       readInFlight;

  rr_arb2 uArb (
    .clk    (clk),
    .rstn   (rstn),
    .enable (rstn & ~scrubBusy),
    .valid  (req_valid),
    .grant  (grant)
  );

  assign req_ready    = grant;
  assign accept       = |grant;
  assign grantIdx     = grant[1];
  assign readInFlight = (ram_en & ~ram_we) | rdPend;

  always_comb begin
    selOp       = '0;
    selOp.we    = grantIdx ? req_we[1] : req_we[0];
    selOp.addr  = REQ_ADDR_MAX_W'(grantIdx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                           : req_addr[ADDR_WIDTH-1:0]);
    selOp.wdata = REQ_DATA_MAX_W'(grantIdx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                           : req_wdata[DATA_WIDTH-1:0]);
  end

  // RAM port drive. The scrubber and requesters never both want the port:
  // grants are blocked while the scrubber is busy.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      issueId    <= 1'b0;
      issueScrub <= 1'b0;
    end else begin
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      issueScrub <= 1'b0;
      if (scrubIssueRd) begin
        ram_en     <= 1'b1;
        ram_addr   <= scrubAddrOut();
        issueScrub <= 1'b1;
      end else if (scrubIssueWb) begin
        ram_en     <= 1'b1;
        ram_we     <= 1'b1;
        ram_addr   <= scrubAddrOut();
        ram_din    <= ram_dout;
        issueScrub <= 1'b1;
      end else if (accept) begin
        ram_en   <= 1'b1;
        ram_we   <= selOp.we;
        ram_addr <= ADDR_WIDTH'(selOp.addr);
        ram_din  <= DATA_WIDTH'(selOp.wdata);
        issueId  <= grantIdx;
      end
    end
  end

  // Read tracking: rdPend marks the cycle in which ram_dout/ram_err belong to a read.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdPend  <= 1'b0;
      rdId    <= 1'b0;
      rdScrub <= 1'b0;
    end else begin
      rdPend  <= ram_en & ~ram_we;
      rdId    <= issueId;
      rdScrub <= issueScrub;
    end
  end

  // Responses and error counting. Scrub reads count errors (this is the
  // only place err_cnt moves) but never raise rsp_valid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      rsp_valid <= rdPend & ~rdScrub;
      if (rdPend && !rdScrub) begin
        rsp_id    <= rdId;
        rsp_rdata <= ram_dout;
        rsp_err   <= ram_err;
      end
      if (rdPend && ram_err && !(&err_cnt)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

`ifdef ECC_SCRUB_EN
  localparam int unsigned DEPTH  = depthOf(ADDR_WIDTH);
  localparam int          IDLE_W = $clog2(SCRUB_INTERVAL + 1);

  scrub_state_t          state;
  scrub_state_t          stateNext;
  logic [IDLE_W-1:0]     idleCnt;
  logic [ADDR_WIDTH-1:0] scrubAddr;
  logic                  goScrub;
  logic                  stepDone;

  function automatic logic [ADDR_WIDTH-1:0] scrubAddrOut();
    return scrubAddr;
  endfunction

  assign goScrub = (state == IDLE) && (req_valid == 2'b00) && !readInFlight &&
                   (idleCnt == IDLE_W'(SCRUB_INTERVAL - 1));

  // Idle counter holds (rather than clears) while a read drains.
  always_ff @(posedge clk) begin
    if (!rstn || state != IDLE || req_valid != 2'b00 || goScrub) begin
      idleCnt <= '0;
    end else if (!readInFlight) begin
      idleCnt <= idleCnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      scrubAddr <= '0;
    end else if (stepDone) begin
      scrubAddr <= (scrubAddr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : scrubAddr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:       if (goScrub) stateNext = SCRUB_RD;
      SCRUB_RD:   stateNext = SCRUB_WAIT;
      SCRUB_WAIT: stateNext = SCRUB_CHK;
      SCRUB_CHK:  stateNext = ram_err ? SCRUB_WB : IDLE;
      SCRUB_WB:   stateNext = IDLE;
      default:    stateNext = IDLE;
    endcase
  end

  // In SCRUB_CHK ram_dout/ram_err belong to the scrub read issued in SCRUB_RD.
  always_comb begin
    scrubBusy    = (state != IDLE);
    scrubIssueRd = (state == SCRUB_RD);
    scrubIssueWb = (state == SCRUB_CHK) && ram_err;
    stepDone     = ((state == SCRUB_CHK) && !ram_err) || (state == SCRUB_WB);
  end
`else
  logic unusedScrubCfg;

  function automatic logic [ADDR_WIDTH-1:0] scrubAddrOut();
    return '0;
  endfunction

  assign unusedScrubCfg = (SCRUB_INTERVAL < 4);
  assign scrubBusy      = 1'b0;
  assign scrubIssueRd   = 1'b0;
  assign scrubIssueWb   = 1'b0;
`endif

  assign scrub_busy = scrubBusy;

endmodule

// File: tb/tb_ecc_ram_port_arbiter.sv
// tb/tb_ecc_ram_port_arbiter.sv - scoreboard bench for ecc_ram_port_arbiter
module tb_ecc_ram_port_arbiter;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int EW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic [1:0]    req_valid, req_ready, req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic          rsp_valid, rsp_id, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          ram_en, ram_we, ram_err;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic [EW-1:0] err_cnt;
  logic          scrub_busy;

  ecc_ram_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERR_CNT_W(EW), .SCRUB_INTERVAL(16)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_err(ram_err),
    .err_cnt(err_cnt), .scrub_busy(scrub_busy)
  );

  // RAM model: data corrected by construction, error flag injected by the bench.
  logic [DW-1:0] mem [8];
  logic          forceErr;
  logic [7:0]    errMask;
  int            wbCount = 0;
  logic [AW-1:0] wbAddr;
  logic [DW-1:0] wbData;

  always @(posedge clk) begin
    if (!rstn) ram_err <= 1'b0;
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_din;
        if (scrub_busy) begin
          wbCount <= wbCount + 1;
          wbAddr  <= ram_addr;
          wbData  <= ram_din;
        end
      end else begin
        ram_dout <= mem[ram_addr];
        ram_err  <= forceErr | errMask[ram_addr];
      end
    end
  end

  // Scoreboard
  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t          expQ[$];
  exp_t          eIn, eOut;
  logic [DW-1:0] refMem [8];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rsp_valid) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got id=%0d data=%h want no response", rsp_id, rsp_rdata);
      end else begin
        eOut = expQ.pop_front();
        if (rsp_id !== eOut.id || rsp_rdata !== eOut.data || rsp_err !== eOut.err || cyc != eOut.cyc) begin
          errors++;
          $display("FAIL rsp got id=%0d data=%h err=%0d cyc=%0d want id=%0d data=%h err=%0d cyc=%0d",
                   rsp_id, rsp_rdata, rsp_err, cyc, eOut.id, eOut.data, eOut.err, eOut.cyc);
        end
      end
    end
    if (rstn) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          if (req_we[i]) begin
            refMem[req_addr[i*AW +: AW]] = req_wdata[i*DW +: DW];
          end else begin
            eIn.id   = 1'(i);
            eIn.data = refMem[req_addr[i*AW +: AW]];
            eIn.err  = forceErr | errMask[req_addr[i*AW +: AW]];
            eIn.cyc  = cyc + 3;
            expQ.push_back(eIn);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic issue(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k;
    k = 0;
    drive(i, we, a, d);
    #1;
    while (!req_ready[i] && k < 20) begin
      @(posedge clk);
      #2;
      k++;
    end
    checks++;
    if (k == 20) begin
      errors++;
      $display("FAIL issue_timeout req=%0d got ready=0 want 1", i);
    end
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (expQ.size() != 0 && k < 20) begin
      step();
      k++;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d want 0", expQ.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic bad;
    rstn = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    forceErr = 1'b0; errMask = '0;
    repeat (3) step();

    // Reset state
    check("rst_rsp", {rsp_valid, rsp_id, rsp_err, rsp_rdata}, 0);
    check("rst_ram", {ram_en, ram_we, ram_addr, ram_din}, 0);
    check("rst_misc", {err_cnt, scrub_busy}, 0);
    req_valid = 2'b11;
    #1;
    check("rst_ready", req_ready, 0);
    req_valid = 2'b00;
    rstn = 1'b1;
    step();

    // Writes, then back-to-back reads; write then read same address
    issue(0, 1'b1, 3'd0, 8'hA5);
    check("ram_wr_drive", {ram_en, ram_we, ram_addr, ram_din}, {1'b1, 1'b1, 3'd0, 8'hA5});
    issue(0, 1'b1, 3'd1, 8'h3C);
    issue(0, 1'b0, 3'd0, 8'h00);
    issue(0, 1'b0, 3'd1, 8'h00);
    issue(0, 1'b1, 3'd3, 8'h77);
    issue(0, 1'b0, 3'd3, 8'h00);
    drain();
    check("err_cnt_clean", err_cnt, 0);

    // Error injection to saturation, requester 1 only
    forceErr = 1'b1;
    for (int i = 0; i < 300; i++) issue(1, 1'b0, 3'(i % 2), 8'h00);
    drain();
    forceErr = 1'b0;
    repeat (2) step();
    check("err_cnt_sat", err_cnt, 8'hFF);
    check("rsp_hold_data", rsp_rdata, 8'h3C);
    check("rsp_hold_err", {rsp_valid, rsp_err}, 2'b01);

    // Both requesters tied for 6 cycles: last grant was requester 1
    drive(0, 1'b0, 3'd0, 8'h00);
    drive(1, 1'b0, 3'd1, 8'h00);
    #1;
    for (int i = 0; i < 6; i++) begin
      check("rr_grant", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
    end
    req_valid = 2'b00;
    drain();
    check("err_cnt_still_sat", err_cnt, 8'hFF);

    // Reset with two reads in flight
    issue(0, 1'b0, 3'd0, 8'h00);
    issue(1, 1'b0, 3'd1, 8'h00);
    rstn = 1'b0;
    expQ.delete();
    step();
    check("midrst_rsp", {rsp_valid, rsp_id, rsp_err, rsp_rdata}, 0);
    check("midrst_ram", {ram_en, ram_we, ram_addr, ram_din, err_cnt}, 0);
    drive(0, 1'b0, 3'd0, 8'h00);
    drive(1, 1'b0, 3'd1, 8'h00);
    #1;
    check("midrst_ready", req_ready, 0);
    rstn = 1'b1;
    #1;
    check("tie_after_reset", req_ready, 2'b01);
    check("no_issue_at_release", ram_en, 0);
    step();
    req_valid = 2'b00;
    check("first_issue_after_reset", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 3'd0});
    drain();

`ifdef ECC_SCRUB_EN
    // Scrub: error at addr 0, stall a request mid-step, then walk to the wrap
    errMask = 8'h01;
    k = 0;
    while (!scrub_busy && k < 40) begin step(); k++; end
    check("scrub_start", scrub_busy, 1);
    drive(0, 1'b0, 3'd1, 8'h00);
    #1;
    bad = 1'b0;
    k = 0;
    while (scrub_busy && k < 10) begin
      if (req_ready != 2'b00) bad = 1'b1;
      step();
      k++;
    end
    check("scrub_stall", bad, 0);
    check("scrub_end", scrub_busy, 0);
    check("grant_after_scrub", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    errMask = 8'h00;
    check("scrub_wb_count", wbCount, 1);
    check("scrub_wb_addr_data", {wbAddr, wbData}, {3'd0, 8'hA5});
    check("scrub_err_cnt", err_cnt, 1);
    drain();
    for (int s = 1; s <= 8; s++) begin
      k = 0;
      while (!scrub_busy && k < 40) begin step(); k++; end
      check("scrub_step_start", scrub_busy, 1);
      step();
      check("scrub_rd_addr", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 3'(s % 8)});
      k = 0;
      while (scrub_busy && k < 10) begin step(); k++; end
      check("scrub_step_end", scrub_busy, 0);
    end
    check("scrub_err_cnt_final", err_cnt, 1);
`else
    // No scrubber: a long idle stretch leaves the port untouched
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ram_en || scrub_busy) bad = 1'b1;
      step();
    end
    check("idle_quiet", bad, 0);
`endif

    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
